// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the tone frequency meter.
// FREQ_METER_AVG_EN widens the divider for the four-period average.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } state_t;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned AVG_SHIFT    = 2;

`ifdef FREQ_METER_AVG_EN
    localparam int unsigned DIV_W = 32 + AVG_SHIFT;
`else
    localparam int unsigned DIV_W = 32;
`endif

endpackage

// File: rtl/freq_meter_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, W cycles per divide.
// done is high during the final iteration; quotient is valid only while done is high.
module seq_divider #(
    parameter int unsigned W = 32
) (
    input  logic         in_clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] numerator,
    input  logic [W-1:0] denominator,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  q_r;
    logic [W-1:0]  rem_r;
    logic [W-1:0]  den_r;
    logic [CW-1:0] iter_r;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          q_bit;

    // remainder stays below the divisor, so the shifted value fits in W+1 bits
    always_comb begin
        shifted = {rem_r, q_r[W-1]};
        diff    = shifted - {1'b0, den_r};
        q_bit   = ~diff[W];
    end

    assign busy     = (iter_r != '0);
    assign done     = (iter_r == CW'(1));
    assign quotient = {q_r[W-2:0], q_bit};

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= '0;
            rem_r  <= '0;
            den_r  <= '0;
            iter_r <= '0;
        end else if (start) begin
            q_r    <= numerator;
            rem_r  <= '0;
            den_r  <= denominator;
            iter_r <= CW'(W);
        end else if (busy) begin
            rem_r  <= q_bit ? diff[W-1:0] : shifted[W-1:0];
            q_r    <= {q_r[W-2:0], q_bit};
            iter_r <= iter_r - CW'(1);
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Tone frequency meter: freq_out = floor(CLK_FREQ / period) in Hz.
// Define FREQ_METER_AVG_EN to divide (CLK_FREQ << 2) by the sum of four periods.
//
// state   | meaning
// IDLE    | no tone seen; waiting for the first rising edge
// MEASURE | counting the period since the last edge, timeout armed
// DIVIDE  | divider running; edges restart the counter but are not measured
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = DEF_CLK_FREQ,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        in_clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic [31:0] freq_out,
    output logic        freq_valid,
    output logic        busy,
    output logic        no_signal
);
    logic             sync1, sync2, sync3, edge_q;
    logic [31:0]      per_cnt;
    logic             timeout_cond;
    state_t           state, state_nx;
    logic             meas_edge, div_start, timeout_hit;
    logic [DIV_W-1:0] div_num, div_den, div_quot;
    logic             div_busy, div_done;

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= tone_in;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n)
            per_cnt <= '0;
        else if (edge_q)
            per_cnt <= 32'd1;
        else if (per_cnt != '1)
            per_cnt <= per_cnt + 32'd1;
    end

    assign timeout_cond = (per_cnt >= 32'(TIMEOUT_CYCLES));

`ifdef FREQ_METER_AVG_EN
    logic [DIV_W-1:0] acc;
    logic [1:0]       n_per;
    logic             group_done;

    assign group_done = (n_per == 2'd3);
    assign meas_edge  = edge_q & group_done;
    assign div_num    = DIV_W'(CLK_FREQ) << AVG_SHIFT;
    assign div_den    = acc + DIV_W'(per_cnt);

    // a group completing while the divider is busy is discarded and restarted
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            n_per <= '0;
        end else if (state == IDLE || timeout_hit || (edge_q && group_done)) begin
            acc   <= '0;
            n_per <= '0;
        end else if (edge_q) begin
            acc   <= acc + DIV_W'(per_cnt);
            n_per <= n_per + 2'd1;
        end
    end
`else
    assign meas_edge = edge_q;
    assign div_num   = DIV_W'(CLK_FREQ);
    assign div_den   = DIV_W'(per_cnt);
`endif

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (edge_q) state_nx = MEASURE;
            MEASURE: begin
                if (meas_edge)
                    state_nx = DIVIDE;
                else if (!edge_q && timeout_cond)
                    state_nx = IDLE;
            end
            DIVIDE:  if (div_done) state_nx = MEASURE;
            default: state_nx = IDLE;
        endcase
    end

    // an edge landing on the timeout cycle wins and is measured normally
    always_comb begin
        div_start   = 1'b0;
        timeout_hit = 1'b0;
        if (state == MEASURE) begin
            div_start   = meas_edge;
            timeout_hit = !edge_q && timeout_cond;
        end
    end

    seq_divider #(.W(DIV_W)) u_div (
        .in_clk      (in_clk),
        .rst_n       (rst_n),
        .start       (div_start),
        .numerator   (div_num),
        .denominator (div_den),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (div_quot)
    );

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_out   <= '0;
            freq_valid <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            freq_valid <= div_done | timeout_hit;
            if (div_done) begin
                freq_out  <= div_quot[31:0];
                no_signal <= 1'b0;
            end else if (timeout_hit) begin
                freq_out  <= '0;
                no_signal <= 1'b1;
            end
        end
    end

    assign busy = div_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: directed and random tone periods
// compared against an edge-level reference model of the meter.
module tb_freq_meter;
    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int          TO     = 1000;

    logic        in_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        tone_in = 1'b0;
    logic [31:0] freq_out;
    logic        freq_valid, busy, no_signal;

    freq_meter #(.CLK_FREQ(CLK_HZ), .TIMEOUT_CYCLES(TO)) dut (
        .in_clk     (in_clk),
        .rst_n      (rst_n),
        .tone_in    (tone_in),
        .freq_out   (freq_out),
        .freq_valid (freq_valid),
        .busy       (busy),
        .no_signal  (no_signal)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        int          c;
        logic [31:0] v;
        logic        ns;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc = 0;
    int  busy_cnt = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    // reference model state, in units of the cycle where tone_in rises
    int  m_state = 0;
    int  m_last  = 0;
    int  m_ready = 0;
    int  m_meas  = 0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // result appears 3 sync/edge cycles + 33 divide cycles after the rise
    function automatic void model_advance(input int now);
        if (m_state == 1 && now > m_last + TO) begin
            exp_q.push_back('{m_last + TO + 4, 32'd0, 1'b1});
            m_state = 0;
        end
    endfunction

    function automatic void model_rise(input int k);
        model_advance(k);
        if (m_state == 0) begin
            m_state = 1;
            m_ready = k;
        end else if (k >= m_ready) begin
            exp_q.push_back('{k + 36, 32'(CLK_HZ / 32'(k - m_last)), 1'b0});
            m_ready = k + 33;
            m_meas++;
        end
        m_last = k;
    endfunction

    function automatic void model_reset();
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].c >= cyc)
            void'(exp_q.pop_back());
        m_state = 0;
    endfunction

    task automatic tick();
        @(negedge in_clk);
        if (freq_valid) obs_q.push_back('{cyc, freq_out, no_signal});
        if (busy) busy_cnt++;
        @(posedge in_clk);
        #1;
        cyc++;
    endtask

    task automatic tone_cycle(input int p);
        tone_in = 1'b1;
        model_rise(cyc);
        repeat (p / 2) tick();
        tone_in = 1'b0;
        repeat (p - p / 2) tick();
    endtask

    task automatic quiet(input int n);
        tone_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_events(input string ph);
        ev_t e, o;
        while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            e = exp_q.pop_front();
            chk({ph, "_present"}, 64'(obs_q.size() != 0), 64'd1);
            if (obs_q.size() != 0) begin
                o = obs_q.pop_front();
                chk({ph, "_cycle"}, 64'(o.c), 64'(e.c));
                chk({ph, "_freq"}, 64'(o.v), 64'(e.v));
                chk({ph, "_no_signal"}, 64'(o.ns), 64'(e.ns));
            end
        end
        chk({ph, "_extra_pulses"}, 64'(obs_q.size()), 64'd0);
        obs_q.delete();
    endtask

    initial begin
        int b0, m0, k;

        @(posedge in_clk);
        #1;
        repeat (3) tick();
        chk("rst_freq_out", 64'(freq_out), 64'd0);
        chk("rst_freq_valid", 64'(freq_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_no_signal", 64'(no_signal), 64'd1);
        rst_n = 1'b1;
        repeat (3) tick();

        b0 = busy_cnt; m0 = m_meas;
        repeat (6) tone_cycle(100);
        quiet(40);
        check_events("p100");
        chk("p100_busy_cycles", 64'(busy_cnt - b0), 64'(32 * (m_meas - m0)));
        chk("p100_no_signal_low", 64'(no_signal), 64'd0);
        chk("p100_freq_out", 64'(freq_out), 64'd500000);

        b0 = busy_cnt; m0 = m_meas;
        repeat (10) tone_cycle(20);
        quiet(40);
        check_events("p20");
        chk("p20_busy_cycles", 64'(busy_cnt - b0), 64'(32 * (m_meas - m0)));
        chk("p20_freq_out", 64'(freq_out), 64'd2500000);

        repeat (5) tone_cycle(33);
        repeat (5) tone_cycle(32);
        quiet(40);
        check_events("p33_p32");

        repeat (20) tone_cycle(int'($urandom_range(20, 600)));
        quiet(40);
        check_events("random");

        repeat (2) tone_cycle(100);
        quiet(1100);
        model_advance(cyc);
        check_events("timeout");
        chk("timeout_no_signal", 64'(no_signal), 64'd1);
        chk("timeout_freq_out", 64'(freq_out), 64'd0);
        repeat (3) tone_cycle(100);
        quiet(40);
        check_events("restart");

        tone_cycle(100);
        tone_in = 1'b1;
        model_rise(cyc);
        k = cyc;
        repeat (13) tick();
        check_events("pre_reset");
        chk("mid_divide_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_freq_out", 64'(freq_out), 64'd0);
        chk("async_rst_freq_valid", 64'(freq_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_no_signal", 64'(no_signal), 64'd1);
        model_reset();
        tone_in = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_events("during_reset");
        repeat (3) tone_cycle(100);
        quiet(40);
        check_events("post_reset");
        chk("post_reset_after_edge", 64'(cyc > k + 36), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
